link_pkt_arbiter: RTL and testbench

//   Packet-granular round-robin arbiter. Shares one credit-flow NoC link (tx/cr/eop/data) between
//   N_REQ local requesters. Once granted, a requester holds the link until its EOP flit transfers.
//   A stall watchdog flags links that hang mid-packet, for example a fault-injected link.

---
 rtl/link_pkt_arbiter.sv | 136 +++++++++++++
 tb/tb_link_pkt_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one credit-flow link between N_REQ requesters,
// with a mid-packet stall watchdog and a completed-packet counter.
module link_pkt_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned FLIT_WIDTH  = 32,
   parameter int unsigned STALL_LIMIT = 256
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [N_REQ-1:0]              tx_i,
   input  logic [N_REQ-1:0]              eop_i,
   input  logic [N_REQ*FLIT_WIDTH-1:0]   data_i,
   output logic [N_REQ-1:0]              cr_o,
   output logic                          tx_o,
   output logic                          eop_o,
   output logic [FLIT_WIDTH-1:0]         data_o,
   input  logic                          cr_i,
   output logic [$clog2(N_REQ)-1:0]      owner_o,
   output logic                          busy_o,
   output logic                          hang_o,
   output logic                          hang_flag_o,
   output logic [31:0]                   pkt_cnt_o
);

   localparam int unsigned IdxW = $clog2(N_REQ);
   localparam int unsigned CntW = $clog2(STALL_LIMIT + 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   winner;
   logic [IdxW-1:0]   cand [N_REQ];
   logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
   logic              hang_q, hang_d;
   logic              hang_flag_q, hang_flag_d;
   logic [31:0]       pkt_cnt_q, pkt_cnt_d;
   logic              own_tx;
   logic              xfer;

   // cand[k] is the k-th requester in priority order starting at rr_ptr
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         cand[k] = IdxW'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
      end
   end

   // Scanning from lowest priority upward leaves the highest-priority requester in winner
   always_comb begin
      winner = rr_ptr_q;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (tx_i[cand[i]]) winner = cand[i];
      end
   end

   assign own_tx = tx_i[owner_q];
   assign xfer   = (state_q == StBusy) && own_tx && cr_i;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      stall_cnt_d = stall_cnt_q;
      hang_d      = 1'b0;
      hang_flag_d = hang_flag_q;
      pkt_cnt_d   = pkt_cnt_q;
      unique case (state_q)
         StIdle: begin
            stall_cnt_d = '0;
            if (|tx_i) begin
               owner_d = winner;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (xfer) begin
               stall_cnt_d = '0;
               hang_flag_d = 1'b0;
               if (eop_i[owner_q]) begin
                  state_d   = StIdle;
                  rr_ptr_d  = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                  pkt_cnt_d = pkt_cnt_q + 32'd1;
               end
            end else if (stall_cnt_q != CntW'(STALL_LIMIT)) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
               if (stall_cnt_q == CntW'(STALL_LIMIT - 1)) begin
                  hang_d      = 1'b1;
                  hang_flag_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         stall_cnt_q <= '0;
         hang_q      <= 1'b0;
         hang_flag_q <= 1'b0;
         pkt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         stall_cnt_q <= stall_cnt_d;
         hang_q      <= hang_d;
         hang_flag_q <= hang_flag_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   always_comb begin
      tx_o   = 1'b0;
      eop_o  = 1'b0;
      data_o = '0;
      cr_o   = '0;
      if (state_q == StBusy) begin
         tx_o          = own_tx;
         eop_o         = eop_i[owner_q];
         data_o        = data_i[32'(owner_q)*FLIT_WIDTH +: FLIT_WIDTH];
         cr_o[owner_q] = cr_i;
      end
   end

   assign owner_o     = owner_q;
   assign busy_o      = (state_q == StBusy);
   assign hang_o      = hang_q;
   assign hang_flag_o = hang_flag_q;
   assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_link_pkt_arbiter.sv
// Self-checking bench for link_pkt_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a packet-level reference model.
module tb_link_pkt_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int SL = 256;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   tx = '0;
   logic [N-1:0]   eop = '0;
   logic [N*W-1:0] data = '0;
   logic           cr = 1'b0;
   logic [N-1:0]   cr_o;
   logic           tx_o, eop_o, busy_o, hang_o, hang_flag_o;
   logic [W-1:0]   data_o;
   logic [1:0]     owner_o;
   logic [31:0]    pkt_cnt_o;

   int errors = 0;
   int checks = 0;

   link_pkt_arbiter #(.N_REQ(N), .FLIT_WIDTH(W), .STALL_LIMIT(SL)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tx_i        (tx),
      .eop_i       (eop),
      .data_i      (data),
      .cr_o        (cr_o),
      .tx_o        (tx_o),
      .eop_o       (eop_o),
      .data_o      (data_o),
      .cr_i        (cr),
      .owner_o     (owner_o),
      .busy_o      (busy_o),
      .hang_o      (hang_o),
      .hang_flag_o (hang_flag_o),
      .pkt_cnt_o   (pkt_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: link ownership, round-robin pointer, completed packets and the
   // number of consecutive stalled cycles since the last transfer (not saturated).
   bit          m_busy;
   int          m_owner, m_rr, m_stalls;
   logic [31:0] m_pkt;

   function automatic void m_reset();
      m_busy = 0; m_owner = 0; m_rr = 0; m_stalls = 0; m_pkt = 0;
   endfunction

   function automatic void m_step();
      if (!m_busy) begin
         m_stalls = 0;
         for (int k = 0; k < N; k++) begin
            if (tx[(m_rr + k) % N]) begin
               m_owner = (m_rr + k) % N;
               m_busy  = 1;
               break;
            end
         end
      end else if (tx[m_owner] && cr) begin
         m_stalls = 0;
         if (eop[m_owner]) begin
            m_busy = 0;
            m_rr   = (m_owner + 1) % N;
            m_pkt++;
         end
      end else begin
         m_stalls++;
      end
   endfunction

   task automatic check_model(input int cyc);
      logic [3:0]  e_cr;
      logic [31:0] e_data;
      logic        e_tx, e_eop, e_hang, e_flag;
      e_cr   = m_busy ? (4'(cr) << m_owner) : 4'b0;
      e_data = m_busy ? data[m_owner*W +: W] : 32'h0;
      e_tx   = m_busy && tx[m_owner];
      e_eop  = m_busy && eop[m_owner];
      e_hang = m_busy && (m_stalls == SL);
      e_flag = m_busy && (m_stalls >= SL);
      check($sformatf("rand%0d ctl", cyc),
            {busy_o, owner_o, tx_o, eop_o, cr_o, hang_o, hang_flag_o},
            {1'(m_busy), 2'(m_owner), e_tx, e_eop, e_cr, e_hang, e_flag});
      check($sformatf("rand%0d data", cyc), data_o, e_data);
      check($sformatf("rand%0d pkt", cyc), pkt_cnt_o, m_pkt);
   endtask

   task automatic apply_reset;
      rst_n = 1'b0; tx = '0; eop = '0; cr = 1'b0; data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
   endtask

   typedef struct packed {
      logic [3:0]  tx;
      logic [3:0]  eop;
      logic        cr;
      logic [31:0] d2;
      logic        busy;
      logic [1:0]  owner;
      logic        tx_o;
      logic        eop_o;
      logic [3:0]  cr_o;
      logic [31:0] data_o;
      logic [31:0] pkt;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int owner_seq [5];
      int hang_cnt, pulse_at;

      // Req 2 sends a 3-flit packet, then req 0 while req 3 waits, then req 3
      vecs[0]  = '{4'b0100, 4'b0000, 1'b1, 32'h11, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'd0};
      vecs[1]  = '{4'b0100, 4'b0000, 1'b1, 32'h11, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 32'h11,       32'd0};
      vecs[2]  = '{4'b0100, 4'b0000, 1'b1, 32'h22, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 32'h22,       32'd0};
      vecs[3]  = '{4'b0100, 4'b0100, 1'b1, 32'h33, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0100, 32'h33,       32'd0};
      vecs[4]  = '{4'b0000, 4'b0000, 1'b1, 32'h0,  1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 32'h0,        32'd1};
      vecs[5]  = '{4'b0001, 4'b0000, 1'b1, 32'h0,  1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 32'h0,        32'd1};
      vecs[6]  = '{4'b1001, 4'b0000, 1'b1, 32'h0,  1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 32'hC0DE0000, 32'd1};
      vecs[7]  = '{4'b1001, 4'b0001, 1'b1, 32'h0,  1'b1, 2'd0, 1'b1, 1'b1, 4'b0001, 32'hC0DE0000, 32'd1};
      vecs[8]  = '{4'b1000, 4'b0000, 1'b1, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'd2};
      vecs[9]  = '{4'b1000, 4'b1000, 1'b1, 32'h0,  1'b1, 2'd3, 1'b1, 1'b1, 4'b1000, 32'hC0DE0003, 32'd2};
      vecs[10] = '{4'b0000, 4'b0000, 1'b1, 32'h0,  1'b0, 2'd3, 1'b0, 1'b0, 4'b0000, 32'h0,        32'd3};

      apply_reset();
      #1;
      check("reset ctl", {busy_o, owner_o, tx_o, eop_o, cr_o, hang_o, hang_flag_o}, 11'h0);
      check("reset pkt", pkt_cnt_o, 32'd0);
      for (int i = 0; i < 11; i++) begin
         tx   = vecs[i].tx;
         eop  = vecs[i].eop;
         cr   = vecs[i].cr;
         data = {32'hC0DE0003, vecs[i].d2, 32'hC0DE0001, 32'hC0DE0000};
         #1;
         check($sformatf("vec%0d ctl", i), {busy_o, owner_o, tx_o, eop_o, cr_o},
               {vecs[i].busy, vecs[i].owner, vecs[i].tx_o, vecs[i].eop_o, vecs[i].cr_o});
         check($sformatf("vec%0d data", i), data_o, vecs[i].data_o);
         check($sformatf("vec%0d pkt", i), pkt_cnt_o, vecs[i].pkt);
         tick();
      end

      // All requesters saturated with single-flit packets: 0,1,2,3,0 with idle bubbles
      owner_seq = '{0, 1, 2, 3, 0};
      apply_reset();
      tx = 4'b1111; eop = 4'b1111; cr = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (k % 2 == 0) begin
            check($sformatf("rr%0d idle", k), {busy_o, cr_o}, 5'b0);
         end else begin
            check($sformatf("rr%0d grant", k), {busy_o, owner_o, cr_o},
                  {1'b1, 2'(owner_seq[k/2]), 4'(1 << owner_seq[k/2])});
         end
         tick();
      end

      // Req 1 stalls mid-packet for 300 cycles: exactly one hang pulse
      apply_reset();
      tx = 4'b0010; eop = 4'b0000; cr = 1'b1;
      tick();
      #1;
      check("stall first flit", {busy_o, owner_o, tx_o, cr_o}, {1'b1, 2'd1, 1'b1, 4'b0010});
      tick();
      cr = 1'b0;
      hang_cnt = 0;
      pulse_at = -1;
      for (int k = 1; k <= 300; k++) begin
         #1;
         if (hang_o) begin
            hang_cnt++;
            pulse_at = k;
         end
         tick();
      end
      check("hang pulse count", 64'(hang_cnt), 64'd1);
      check("hang pulse cycle", 64'(pulse_at), 64'(SL + 1));
      check("hang held grant", {busy_o, owner_o, hang_flag_o, hang_o}, {1'b1, 2'd1, 1'b1, 1'b0});
      cr = 1'b1;
      #1;
      check("hang flag before resume", {hang_flag_o, tx_o}, 2'b11);
      tick();
      check("hang flag cleared", {hang_flag_o, busy_o, owner_o}, {1'b0, 1'b1, 2'd1});

      // Reset mid-packet: req 1 completes one packet, req 2 is reset on flit 2 of 4
      apply_reset();
      tx = 4'b0010; eop = 4'b0010; cr = 1'b1; data = {4{32'h5A5A5A5A}};
      tick();
      tick();
      tx = 4'b0100; eop = 4'b0000;
      tick();
      tick();
      #1;
      check("pre-reset flit2", {busy_o, owner_o, tx_o, pkt_cnt_o}, {1'b1, 2'd2, 1'b1, 32'd1});
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset ctl", {busy_o, owner_o, tx_o, eop_o, cr_o, hang_o, hang_flag_o}, 11'h0);
      check("async reset data", data_o, 32'h0);
      check("async reset pkt", pkt_cnt_o, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tx = 4'b1111; eop = 4'b1111;
      tick();
      check("post-reset rr", {busy_o, owner_o, pkt_cnt_o}, {1'b1, 2'd0, 32'd0});

      // Owner drops tx for 10 cycles: grant held, no hang
      apply_reset();
      tx = 4'b0010; eop = 4'b0000; cr = 1'b1; data = {32'h3, 32'h2, 32'hBEEF0001, 32'h0};
      tick();
      tick();
      tx = 4'b0000;
      repeat (10) tick();
      check("gap held", {busy_o, owner_o, cr_o, hang_o, hang_flag_o},
            {1'b1, 2'd1, 4'b0010, 1'b0, 1'b0});
      check("gap stall_cnt", 64'(dut.stall_cnt_q), 64'd10);
      tx = 4'b0010; eop = 4'b0010;
      #1;
      check("gap resume", {tx_o, eop_o, data_o}, {1'b1, 1'b1, 32'hBEEF0001});
      tick();
      check("gap done", {busy_o, pkt_cnt_o}, {1'b0, 32'd1});

      // Randomized traffic against the reference model
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         tx = 4'($urandom);
         for (int b = 0; b < N; b++) eop[b] = ($urandom_range(2) == 0);
         cr   = ($urandom_range(3) != 0);
         data = {$urandom(), $urandom(), $urandom(), $urandom()};
         #1;
         check_model(c);
         m_step();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
